ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline register; next generation of the fixed 32-bit EX/MEM latch.
- Adds stall-vector handling with bubble insertion and pipeline flush.
- Carries multi-cycle accumulate state (temporary HI/LO and a cycle counter) so madd/msub-style ops survive an EX stall.
- Adds a valid bit and a saturating bubble-count performance counter. Sits between the ex and mem stages; driven by the ctrl block.

Parameters:
- DATA_W, 32, width of the write-data, HI and LO buses.
- REG_AW, 5, destination register address width.
- CNT_W, 2, width of the multi-cycle op counter.
- STALL_W, 6, width of the stall vector from ctrl.
- EX_IDX, 3, stall-vector bit meaning "EX stalled".
- MEM_IDX, 4, stall-vector bit meaning "MEM stalled".
- PERF_W, 16, width of the bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  STALL_W  stall request vector from ctrl.
- flush  in  1  discard the in-flight instruction (exception/branch recovery).
- ex_wd  in  REG_AW  destination register address.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  DATA_W  register write data.
- ex_hi  in  DATA_W  HI write value.
- ex_lo  in  DATA_W  LO write value.
- ex_hilo  in  1  HI/LO write enable.
- ex_hilo_tmp  in  2*DATA_W  partial accumulate result from EX.
- ex_cnt  in  CNT_W  EX multi-cycle step count.
- mem_wd  out  REG_AW  registered ex_wd.
- mem_wreg  out  1  registered ex_wreg.
- mem_wdata  out  DATA_W  registered ex_wdata.
- mem_hi  out  DATA_W  registered ex_hi.
- mem_lo  out  DATA_W  registered ex_lo.
- mem_hilo  out  1  registered ex_hilo.
- mem_valid  out  1  1 = MEM holds a real instruction; 0 = bubble.
- hilo_tmp_o  out  2*DATA_W  accumulate state returned to EX.
- cnt_o  out  CNT_W  step count returned to EX.
- bubble_cnt  out  PERF_W  saturating count of bubbles inserted.

Behaviour:
- All registers update only on the rising clk edge. No combinational input-to-output paths.
- Priority order: rst > flush > hold > bubble > advance.
- Reset (rst=1): every output is 0, including bubble_cnt, hilo_tmp_o and cnt_o. Address outputs reset to the NOP register address (0).
- Flush (rst=0, flush=1): all mem_* outputs set to 0 and mem_valid=0. hilo_tmp_o and cnt_o set to 0. bubble_cnt is unchanged.
  - Flush overrides any stall, including stall[MEM_IDX].
- Hold (stall[MEM_IDX]=1, no flush): every output retains its value, including hilo_tmp_o, cnt_o and bubble_cnt.
- Bubble (stall[EX_IDX]=1, stall[MEM_IDX]=0, no flush):
  - mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_hilo and mem_valid all set to 0.
  - hilo_tmp_o <= ex_hilo_tmp and cnt_o <= ex_cnt, so EX sees its partial result next cycle.
  - bubble_cnt increments by 1, saturating at all-ones (no wrap).
- Advance (stall[EX_IDX]=0, stall[MEM_IDX]=0, no flush):
  - All mem_* outputs take their ex_* inputs; mem_valid=1.
  - hilo_tmp_o and cnt_o clear to 0, so a new multi-cycle op starts clean.
- Latency: exactly 1 cycle from ex_* to mem_* when advancing.
- Other stall bits are ignored (IF/ID/WB stalls, not this stage's concern).
- Widths: ex_hilo_tmp is {hi,lo} packed, MSB half = HI. No arithmetic is performed on data paths; the only arithmetic is the bubble_cnt increment.
- Reset mid-operation: clears accumulate state immediately. A stalled multi-cycle op is abandoned.

Test Plan:
- Reset: rst=1 for 2 cycles with ex_wdata=32'hDEADBEEF, ex_wreg=1 -> all outputs 0, bubble_cnt=0. Release rst with stall=0 -> next edge mem_wdata=32'hDEADBEEF, mem_wreg=1, mem_valid=1.
- Advance: ex_wd=5'd7, ex_hi=32'h1, ex_lo=32'h2, ex_hilo=1, stall=6'b0 -> one edge later mem_wd=7, mem_hi=1, mem_lo=2, mem_hilo=1, cnt_o=0.
- Bubble with accumulate: stall=6'b001000, ex_hilo_tmp=64'h0000_0001_0000_0002, ex_cnt=1.
  - Next edge: mem_valid=0, mem_wreg=0, hilo_tmp_o=64'h0000_0001_0000_0002, cnt_o=1, bubble_cnt=1.
  - Drop stall: next edge cnt_o=0.
- Hold: after an advance with mem_wdata=32'hA5A5A5A5, set stall=6'b011000 for 3 cycles while changing ex_* -> mem_wdata stays 32'hA5A5A5A5, mem_valid=1, bubble_cnt unchanged.
- Flush over stall: stall=6'b011000, flush=1 -> next edge all mem_* 0, mem_valid=0, cnt_o=0.
  - With rst=1 and flush=1 together: also clears bubble_cnt.
- Saturation: PERF_W=2, hold stall=6'b001000 for 5 cycles -> bubble_cnt goes 1,2,3,3,3.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/bubble/flush handling, multi-cycle
// accumulate state carried back to EX, a valid bit and a saturating bubble counter.
module ex_mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 2,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4,
  parameter int PERF_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [REG_AW-1:0]     ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic                  ex_hilo,
  input  logic [2*DATA_W-1:0]   ex_hilo_tmp,
  input  logic [CNT_W-1:0]      ex_cnt,
  output logic [REG_AW-1:0]     mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic                  mem_hilo,
  output logic                  mem_valid,
  output logic [2*DATA_W-1:0]   hilo_tmp_o,
  output logic [CNT_W-1:0]      cnt_o,
  output logic [PERF_W-1:0]     bubble_cnt
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  logic ex_stall;
  logic mem_stall;
  logic unused_stall;

  // Only the EX and MEM stall bits matter here; the rest belong to other stages.
  assign ex_stall     = stall[EX_IDX];
  assign mem_stall    = stall[MEM_IDX];
  assign unused_stall = ^stall;

  logic [REG_AW-1:0]   wd_p1;
  logic                wreg_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [DATA_W-1:0]   hi_p1;
  logic [DATA_W-1:0]   lo_p1;
  logic                hilo_p1;
  logic                vld_p1;
  logic [2*DATA_W-1:0] hilo_tmp_p1;
  logic [CNT_W-1:0]    cnt_p1;
  logic [PERF_W-1:0]   bubble_cnt_p1;

  // ---- EX -> MEM boundary ----

  // Instruction payload and valid: reset/flush clear, MEM stall holds,
  // EX stall injects a bubble, otherwise capture EX.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wd_p1    <= '0;
      wreg_p1  <= 1'b0;
      wdata_p1 <= '0;
      hi_p1    <= '0;
      lo_p1    <= '0;
      hilo_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else if (mem_stall) begin
      wd_p1    <= wd_p1;
      wreg_p1  <= wreg_p1;
      wdata_p1 <= wdata_p1;
      hi_p1    <= hi_p1;
      lo_p1    <= lo_p1;
      hilo_p1  <= hilo_p1;
      vld_p1   <= vld_p1;
    end else if (ex_stall) begin
      wd_p1    <= '0;
      wreg_p1  <= 1'b0;
      wdata_p1 <= '0;
      hi_p1    <= '0;
      lo_p1    <= '0;
      hilo_p1  <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      wd_p1    <= ex_wd;
      wreg_p1  <= ex_wreg;
      wdata_p1 <= ex_wdata;
      hi_p1    <= ex_hi;
      lo_p1    <= ex_lo;
      hilo_p1  <= ex_hilo;
      vld_p1   <= 1'b1;
    end
  end

  // Accumulate state: kept only while EX is stalled mid multi-cycle op, so the
  // partial result comes back to EX next cycle; any other advance starts clean.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hilo_tmp_p1 <= '0;
      cnt_p1      <= '0;
    end else if (mem_stall) begin
      hilo_tmp_p1 <= hilo_tmp_p1;
      cnt_p1      <= cnt_p1;
    end else if (ex_stall) begin
      hilo_tmp_p1 <= ex_hilo_tmp;
      cnt_p1      <= ex_cnt;
    end else begin
      hilo_tmp_p1 <= '0;
      cnt_p1      <= '0;
    end
  end

  // Bubble counter: counts only inserted bubbles; flush and hold leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_p1 <= '0;
    end else if (!flush && !mem_stall && ex_stall) begin
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign mem_wd     = wd_p1;
  assign mem_wreg   = wreg_p1;
  assign mem_wdata  = wdata_p1;
  assign mem_hi     = hi_p1;
  assign mem_lo     = lo_p1;
  assign mem_hilo   = hilo_p1;
  assign mem_valid  = vld_p1;
  assign hilo_tmp_o = hilo_tmp_p1;
  assign cnt_o      = cnt_p1;
  assign bubble_cnt = bubble_cnt_p1;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed table-driven bench for ex_mem_stage, plus a narrow-counter instance
// exercising bubble_cnt saturation.
`timescale 1ns/1ps
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_hilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] ex_hilo_tmp;
  logic [1:0]  ex_cnt;

  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_hilo, mem_valid;
  logic [31:0] mem_wdata, mem_hi, mem_lo;
  logic [63:0] hilo_tmp_o;
  logic [1:0]  cnt_o;
  logic [15:0] bubble_cnt;

  logic        rst2, flush2;
  logic [5:0]  stall2;
  logic [4:0]  mem_wd2;
  logic        mem_wreg2, mem_hilo2, mem_valid2;
  logic [31:0] mem_wdata2, mem_hi2, mem_lo2;
  logic [63:0] hilo_tmp_o2;
  logic [1:0]  cnt_o2;
  logic [1:0]  bubble_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo(ex_hilo),
    .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_hilo(mem_hilo),
    .mem_valid(mem_valid), .hilo_tmp_o(hilo_tmp_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt)
  );

  ex_mem_stage #(.PERF_W(2)) dut_sat (
    .clk(clk), .rst(rst2), .stall(stall2), .flush(flush2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo(ex_hilo),
    .ex_hilo_tmp(ex_hilo_tmp), .ex_cnt(ex_cnt),
    .mem_wd(mem_wd2), .mem_wreg(mem_wreg2), .mem_wdata(mem_wdata2),
    .mem_hi(mem_hi2), .mem_lo(mem_lo2), .mem_hilo(mem_hilo2),
    .mem_valid(mem_valid2), .hilo_tmp_o(hilo_tmp_o2), .cnt_o(cnt_o2),
    .bubble_cnt(bubble_cnt2)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo;
    logic [63:0] tmp;
    logic [1:0]  cnt;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_hilo;
    logic        e_valid;
    logic [63:0] e_tmp;
    logic [1:0]  e_cnt;
    logic [15:0] e_bc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic f, input logic [5:0] st,
    input logic [4:0] wd, input logic wr, input logic [31:0] wda,
    input logic [31:0] hi, input logic [31:0] lo, input logic hl,
    input logic [63:0] tmp, input logic [1:0] cn,
    input logic [4:0] ewd, input logic ewr, input logic [31:0] ewda,
    input logic [31:0] ehi, input logic [31:0] elo, input logic ehl,
    input logic ev, input logic [63:0] etmp, input logic [1:0] ecn,
    input logic [15:0] ebc);
    vec_t v;
    v.rst = r; v.flush = f; v.stall = st; v.wd = wd; v.wreg = wr; v.wdata = wda;
    v.hi = hi; v.lo = lo; v.hilo = hl; v.tmp = tmp; v.cnt = cn;
    v.e_wd = ewd; v.e_wreg = ewr; v.e_wdata = ewda; v.e_hi = ehi; v.e_lo = elo;
    v.e_hilo = ehl; v.e_valid = ev; v.e_tmp = etmp; v.e_cnt = ecn; v.e_bc = ebc;
    return v;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0;
    ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_hi = '0; ex_lo = '0;
    ex_hilo = 1'b0; ex_hilo_tmp = '0; ex_cnt = '0;
    rst2 = 1'b1; flush2 = 1'b0; stall2 = '0;

    // Each row: inputs applied for one edge, then outputs expected after that edge.
    // reset twice with live data on the inputs
    vecs.push_back(mk(1,0,6'b000000, 5'd0,1,32'hDEADBEEF, 32'h0,32'h0,0, 64'h0,2'd0,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h0,2'd0,16'd0));
    vecs.push_back(mk(1,0,6'b000000, 5'd0,1,32'hDEADBEEF, 32'h0,32'h0,0, 64'h0,2'd0,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h0,2'd0,16'd0));
    // first advance after reset
    vecs.push_back(mk(0,0,6'b000000, 5'd0,1,32'hDEADBEEF, 32'h0,32'h0,0, 64'h0,2'd0,
                      5'd0,1,32'hDEADBEEF, 32'h0,32'h0,0, 1,64'h0,2'd0,16'd0));
    // advance HI/LO write
    vecs.push_back(mk(0,0,6'b000000, 5'd7,0,32'h0, 32'h1,32'h2,1, 64'h0,2'd0,
                      5'd7,0,32'h0, 32'h1,32'h2,1, 1,64'h0,2'd0,16'd0));
    // bubble carrying accumulate state
    vecs.push_back(mk(0,0,6'b001000, 5'd3,1,32'h55, 32'h9,32'h9,1, 64'h0000_0001_0000_0002,2'd1,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h0000_0001_0000_0002,2'd1,16'd1));
    // stall dropped: advance, accumulate state cleared
    vecs.push_back(mk(0,0,6'b000000, 5'd2,1,32'hA5A5A5A5, 32'h0,32'h0,0, 64'hFFFF_FFFF_FFFF_FFFF,2'd3,
                      5'd2,1,32'hA5A5A5A5, 32'h0,32'h0,0, 1,64'h0,2'd0,16'd1));
    // hold for three cycles while EX inputs change
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,6'b011000, 5'd9,0,32'h12345678, 32'h3,32'h4,1, 64'hABC,2'd2,
                        5'd2,1,32'hA5A5A5A5, 32'h0,32'h0,0, 1,64'h0,2'd0,16'd1));
    // second bubble, then holds must keep the accumulate state
    vecs.push_back(mk(0,0,6'b001000, 5'd1,1,32'h1, 32'h1,32'h1,1, 64'h1111_2222_3333_4444,2'd2,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h1111_2222_3333_4444,2'd2,16'd2));
    vecs.push_back(mk(0,0,6'b011000, 5'd1,1,32'h1, 32'h1,32'h1,1, 64'h5,2'd1,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h1111_2222_3333_4444,2'd2,16'd2));
    vecs.push_back(mk(0,0,6'b010000, 5'd1,1,32'h1, 32'h1,32'h1,1, 64'h5,2'd1,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h1111_2222_3333_4444,2'd2,16'd2));
    // flush beats MEM stall; bubble count kept
    vecs.push_back(mk(0,1,6'b011000, 5'd4,1,32'h77, 32'h1,32'h1,1, 64'h5,2'd1,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h0,2'd0,16'd2));
    // unrelated stall bits ignored: full-scale advance
    vecs.push_back(mk(0,0,6'b100111, 5'd31,1,32'hFFFFFFFF, 32'h80000000,32'h7FFFFFFF,1, 64'h9,2'd3,
                      5'd31,1,32'hFFFFFFFF, 32'h80000000,32'h7FFFFFFF,1, 1,64'h0,2'd0,16'd2));
    // bubble after a valid instruction
    vecs.push_back(mk(0,0,6'b001000, 5'd0,0,32'h0, 32'h0,32'h0,0, 64'h42,2'd3,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h42,2'd3,16'd3));
    // reset with flush and stall: everything including bubble count clears
    vecs.push_back(mk(1,1,6'b011000, 5'd5,1,32'h5, 32'h5,32'h5,1, 64'h5,2'd1,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h0,2'd0,16'd0));
    vecs.push_back(mk(0,0,6'b000000, 5'd6,1,32'hCAFE, 32'h0,32'h0,0, 64'h0,2'd0,
                      5'd6,1,32'hCAFE, 32'h0,32'h0,0, 1,64'h0,2'd0,16'd0));
    // plain flush without stall
    vecs.push_back(mk(0,1,6'b000000, 5'd8,1,32'hBEEF, 32'h1,32'h2,1, 64'h3,2'd1,
                      5'd0,0,32'h0, 32'h0,32'h0,0, 0,64'h0,2'd0,16'd0));

    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush = vecs[i].flush; stall = vecs[i].stall;
      ex_wd = vecs[i].wd; ex_wreg = vecs[i].wreg; ex_wdata = vecs[i].wdata;
      ex_hi = vecs[i].hi; ex_lo = vecs[i].lo; ex_hilo = vecs[i].hilo;
      ex_hilo_tmp = vecs[i].tmp; ex_cnt = vecs[i].cnt;
      @(posedge clk); #1;
      check($sformatf("v%0d mem_wd", i),     64'(mem_wd),     64'(vecs[i].e_wd));
      check($sformatf("v%0d mem_wreg", i),   64'(mem_wreg),   64'(vecs[i].e_wreg));
      check($sformatf("v%0d mem_wdata", i),  64'(mem_wdata),  64'(vecs[i].e_wdata));
      check($sformatf("v%0d mem_hi", i),     64'(mem_hi),     64'(vecs[i].e_hi));
      check($sformatf("v%0d mem_lo", i),     64'(mem_lo),     64'(vecs[i].e_lo));
      check($sformatf("v%0d mem_hilo", i),   64'(mem_hilo),   64'(vecs[i].e_hilo));
      check($sformatf("v%0d mem_valid", i),  64'(mem_valid),  64'(vecs[i].e_valid));
      check($sformatf("v%0d hilo_tmp_o", i), hilo_tmp_o,      vecs[i].e_tmp);
      check($sformatf("v%0d cnt_o", i),      64'(cnt_o),      64'(vecs[i].e_cnt));
      check($sformatf("v%0d bubble_cnt", i), 64'(bubble_cnt), 64'(vecs[i].e_bc));
      @(negedge clk);
    end

    // Saturation on a 2-bit bubble counter: 1,2,3,3,3
    rst2 = 1'b1; stall2 = '0; flush2 = 1'b0;
    @(posedge clk); #1;
    check("sat reset", 64'(bubble_cnt2), 64'd0);
    @(negedge clk);
    rst2 = 1'b0; stall2 = 6'b001000;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("sat bubble %0d", k), 64'(bubble_cnt2), (k < 3) ? 64'(k + 1) : 64'd3);
      check($sformatf("sat valid %0d", k), 64'(mem_valid2), 64'd0);
      @(negedge clk);
    end
    stall2 = '0;
    @(posedge clk); #1;
    check("sat advance bc", 64'(bubble_cnt2), 64'd3);
    check("sat advance valid", 64'(mem_valid2), 64'd1);
    @(negedge clk);
    flush2 = 1'b1;
    @(posedge clk); #1;
    check("sat flush bc", 64'(bubble_cnt2), 64'd3);
    check("sat flush valid", 64'(mem_valid2), 64'd0);
    @(negedge clk);
    flush2 = 1'b0; rst2 = 1'b1;
    @(posedge clk); #1;
    check("sat rst bc", 64'(bubble_cnt2), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
